// File: rtl/matrix_ld_seq_pkg.sv
// Shared types and encodings for the matrix-load sequencer and its write-port arbiter.
package matrix_ld_seq_pkg;

  localparam logic [1:0] WSEL_NONE  = 2'b00;
  localparam logic [1:0] WSEL_REG   = 2'b01;
  localparam logic [1:0] WSEL_SLICE = 2'b10;
  localparam logic [1:0] WSEL_ALL   = 2'b11;

  localparam int MATRIX_SLICES = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WR_SLICE = 3'd2,
    WR_ALL   = 3'd3,
    DONE     = 3'd4
  } ml_state_e;

endpackage

// File: rtl/matrix_ld_seq_wport_arb.sv
// Register-file write-port mux: pipeline writeback always wins, the sequencer
// write is driven and granted only in a cycle with no pipeline write.
module matrix_ld_seq_wport_arb
  import matrix_ld_seq_pkg::*;
(
  input  logic [1:0]   wb_select_i,
  input  logic [4:0]   wb_addr_i,
  input  logic [31:0]  wb_data_i,
  input  logic [127:0] wb_matrix_i,
  input  logic         seq_req_i,
  input  logic [1:0]   seq_select_i,
  input  logic [4:0]   seq_addr_i,
  input  logic [31:0]  seq_data_i,
  input  logic [127:0] seq_matrix_i,
  output logic [1:0]   w_select_o,
  output logic [4:0]   w_regs_addr_o,
  output logic [31:0]  w_regs_data_o,
  output logic [127:0] w_matrix_data_o,
  output logic         seq_grant_o
);

  // Priority mux between pipeline writeback and the pending sequencer write
  always_comb begin
    w_select_o      = wb_select_i;
    w_regs_addr_o   = wb_addr_i;
    w_regs_data_o   = wb_data_i;
    w_matrix_data_o = wb_matrix_i;
    seq_grant_o     = 1'b0;
    if ((wb_select_i == WSEL_NONE) && seq_req_i) begin
      w_select_o      = seq_select_i;
      w_regs_addr_o   = seq_addr_i;
      w_regs_data_o   = seq_data_i;
      w_matrix_data_o = seq_matrix_i;
      seq_grant_o     = 1'b1;
    end else begin
      seq_grant_o     = 1'b0;
    end
  end

endmodule

// File: rtl/matrix_ld_seq.sv
// Matrix-load sequencer: fetches four words over req/ack, then writes the matrix file.
// Optional macro MATRIX_LD_TIMEOUT_EN adds a mem_ack wait timeout that pulses ml_err.
module matrix_ld_seq
  import matrix_ld_seq_pkg::*;
#(
  parameter int STRIDE      = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ml_start,
  input  logic [31:0]  ml_base,
  input  logic         ml_mode,
  output logic         mem_req,
  output logic [31:0]  mem_addr,
  input  logic         mem_ack,
  input  logic [31:0]  mem_rdata,
  input  logic [1:0]   wb_select,
  input  logic [4:0]   wb_addr,
  input  logic [31:0]  wb_data,
  input  logic [127:0] wb_matrix,
  output logic [1:0]   w_select,
  output logic [4:0]   w_regs_addr,
  output logic [31:0]  w_regs_data,
  output logic [127:0] w_matrix_data,
  output logic         ml_busy,
  output logic         ml_done,
  output logic         ml_err
);

  ml_state_e   state_q;
  logic [1:0]  cnt_q;
  logic        mode_q;
  logic [31:0] base_q;
  logic [31:0] mem_addr_q;
  logic        mem_req_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] wbuf_q [MATRIX_SLICES];

  logic [1:0]  cnt_d;
  logic [31:0] addr_d;
  logic        seq_req_s;
  logic [1:0]  seq_sel_s;
  logic        seq_grant_s;

`ifdef MATRIX_LD_TIMEOUT_EN
  localparam int WAIT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [WAIT_W-1:0] wait_q;
  logic              err_q;
`else
  localparam int TMO_UNUSED = TIMEOUT_CYC;
`endif

  // Next word index and its address; the address wraps modulo 2^32
  always_comb begin
    cnt_d     = cnt_q + 2'd1;
    addr_d    = base_q + (32'(cnt_d) * 32'(STRIDE));
    seq_req_s = (state_q == WR_SLICE) || (state_q == WR_ALL);
    seq_sel_s = (state_q == WR_ALL) ? WSEL_ALL : WSEL_SLICE;
  end

  matrix_ld_seq_wport_arb u_arb (
    .wb_select_i     (wb_select),
    .wb_addr_i       (wb_addr),
    .wb_data_i       (wb_data),
    .wb_matrix_i     (wb_matrix),
    .seq_req_i       (seq_req_s),
    .seq_select_i    (seq_sel_s),
    .seq_addr_i      ({3'b000, cnt_q}),
    .seq_data_i      (wbuf_q[cnt_q]),
    .seq_matrix_i    ({wbuf_q[3], wbuf_q[2], wbuf_q[1], wbuf_q[0]}),
    .w_select_o      (w_select),
    .w_regs_addr_o   (w_regs_addr),
    .w_regs_data_o   (w_regs_data),
    .w_matrix_data_o (w_matrix_data),
    .seq_grant_o     (seq_grant_s)
  );

  // Sequencer FSM; every port-facing flag is registered alongside the state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      mode_q     <= 1'b0;
      base_q     <= 32'd0;
      mem_addr_q <= 32'd0;
      mem_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < MATRIX_SLICES; i++) wbuf_q[i] <= 32'd0;
`ifdef MATRIX_LD_TIMEOUT_EN
      wait_q     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MATRIX_LD_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (ml_start) begin
            base_q     <= ml_base;
            mode_q     <= ml_mode;
            cnt_q      <= 2'd0;
            mem_addr_q <= ml_base;
            mem_req_q  <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= REQ;
`ifdef MATRIX_LD_TIMEOUT_EN
            wait_q     <= '0;
`endif
          end
        end
        REQ: begin
          if (mem_ack) begin
            wbuf_q[cnt_q] <= mem_rdata;
`ifdef MATRIX_LD_TIMEOUT_EN
            wait_q        <= '0;
`endif
            if (mode_q) begin
              mem_req_q <= 1'b0;
              state_q   <= WR_SLICE;
            end else if (cnt_q == 2'd3) begin
              mem_req_q <= 1'b0;
              state_q   <= WR_ALL;
            end else begin
              cnt_q      <= cnt_d;
              mem_addr_q <= addr_d;
            end
          end
`ifdef MATRIX_LD_TIMEOUT_EN
          else if (wait_q == WAIT_W'(TIMEOUT_CYC - 1)) begin
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
`endif
        end
        WR_SLICE: begin
          if (seq_grant_s) begin
            if (cnt_q == 2'd3) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              cnt_q      <= cnt_d;
              mem_addr_q <= addr_d;
              mem_req_q  <= 1'b1;
              state_q    <= REQ;
`ifdef MATRIX_LD_TIMEOUT_EN
              wait_q     <= '0;
`endif
            end
          end
        end
        WR_ALL: begin
          if (seq_grant_s) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign ml_busy  = busy_q;
  assign ml_done  = done_q;
`ifdef MATRIX_LD_TIMEOUT_EN
  assign ml_err   = err_q;
`else
  assign ml_err   = 1'b0;
`endif

endmodule

// File: doc/matrix_ld_seq.md
Name: matrix_ld_seq

Overview:
- Multi-cycle sequencer for the matrix-load instruction.
- Fetches four 32-bit words from data memory over a req/ack handshake, then writes them into the 4-slice matrix file of the register file.
- Writes either as one whole-matrix write (w_select=11) or as four slice writes (w_select=10).
- Owns the register-file write port: pipeline writeback always has priority; sequencer writes wait for a free cycle.

Parameters:
- STRIDE, 4: byte offset between consecutive matrix words in memory.
- TIMEOUT_CYC, 255: max cycles waiting for mem_ack (used only with MATRIX_LD_TIMEOUT_EN).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset.
- ml_start  in  1  start pulse; sampled only in IDLE.
- ml_base  in  32  base byte address; latched on accepted start.
- ml_mode  in  1  0 = whole-matrix write, 1 = slice-by-slice; latched on start.
- mem_req  out  1  memory read request.
- mem_addr  out  32  read address.
- mem_ack  in  1  read data valid this cycle.
- mem_rdata  in  32  read data.
- wb_select  in  2  pipeline writeback select (00 none, 01 reg, 10 slice, 11 whole).
- wb_addr  in  5  pipeline writeback address.
- wb_data  in  32  pipeline writeback data.
- wb_matrix  in  128  pipeline whole-matrix data.
- w_select  out  2  to register file.
- w_regs_addr  out  5  to register file.
- w_regs_data  out  32  to register file.
- w_matrix_data  out  128  to register file; slice k at bits [32k+31:32k].
- ml_busy  out  1  high in every state except IDLE; stalls the pipeline front end.
- ml_done  out  1  one-cycle completion pulse.
- ml_err  out  1  one-cycle timeout pulse (0 when feature is off).

Behaviour:
- Reset: clk edge with rst=0 sets state IDLE and cnt=0, and clears the word buffer and all registered outputs. mem_req=0, ml_busy=0, ml_done=0, ml_err=0. Port mux outputs become wb_* (pipeline path only).
- Reset mid-load: abandons the load with no further writes. Slices already written stay as written.
- States:
  - IDLE: on ml_start=1, latch base and mode, cnt=0, go to REQ. ml_start is ignored outside IDLE.
  - REQ: mem_req=1, mem_addr = base + cnt*STRIDE (mod 2^32 wrap). On mem_ack, store mem_rdata into buf[cnt].
    - Slice mode: go to WR_SLICE.
    - Whole mode: if cnt==3 go to WR_ALL, else cnt++ and stay in REQ.
  - WR_SLICE: request write w_select=10, w_regs_addr={3'b0,cnt}, w_regs_data=buf[cnt]. On grant: if cnt==3 go to DONE, else cnt++ and go to REQ.
  - WR_ALL: request write w_select=11, w_matrix_data={buf3,buf2,buf1,buf0}. On grant, go to DONE.
  - DONE: ml_done=1 for exactly one cycle, then IDLE.
- mem_req is registered. mem_addr and mem_req are stable until mem_ack. mem_ack outside REQ is ignored.
- Write-port mux (combinational):
  - wb_select!=00: outputs = wb_*; a pending sequencer write is held (not granted).
  - wb_select==00 and sequencer in WR_*: sequencer write is driven and granted that cycle.
  - Otherwise: w_select=00.
  - A pipeline write in the same cycle as a pending sequencer write passes through and the sequencer write follows. If both target the same slice, the sequencer value lands last.
- Minimum latency, zero-wait ack, start in cycle 0:
  - Whole mode: REQ cycles 1-4, WR_ALL cycle 5, ml_done cycle 6.
  - Slice mode: ml_done cycle 9.
- Each cycle of pipeline priority adds one cycle of latency.

Optional Feature:
- MATRIX_LD_TIMEOUT_EN defined:
  - 8-bit-minimum wait counter, cleared on entering REQ.
  - If mem_ack is absent for TIMEOUT_CYC consecutive REQ cycles: drop mem_req, pulse ml_err for one cycle, go to IDLE with no matrix write. ml_done does not pulse.
- Undefined: no counter; REQ waits indefinitely; ml_err tied to 0.

Decomposition:
- Shared package holds:
  - w_select encodings WSEL_NONE=2'b00, WSEL_REG=2'b01, WSEL_SLICE=2'b10, WSEL_ALL=2'b11.
  - MATRIX_SLICES=4.
  - State enum (IDLE, REQ, WR_SLICE, WR_ALL, DONE).
- One natural sub-module: wport_arb, the combinational pipeline-priority mux plus grant.

Test Plan:
- Whole mode, base=0x100, zero-wait ack, rdata 0x11111111..0x44444444 -> addrs 0x100/104/108/10C; w_select=11 once in cycle 5 with w_matrix_data=0x44444444_33333333_22222222_11111111; ml_done in cycle 6.
- Slice mode, base=0x200, ack 2 cycles late each -> four w_select=10 writes, addr 0..3, data in order; no whole write.
- Slice mode with wb_select=01 (x5=0xDEAD) in the cycle of the slice-2 write -> x5 written first, slice 2 written next cycle, ml_done delayed one cycle.
- ml_start pulsed while busy and rst=0 asserted during the third REQ -> second start ignored; after reset, mem_req=0, w_select=00, no ml_done.
- Base=0xFFFFFFFC -> addresses wrap to 0x0, 0x4, 0x8.
- With MATRIX_LD_TIMEOUT_EN and TIMEOUT_CYC=10, no ack -> ml_err pulse after 10 REQ cycles, IDLE, no write.
